lock_arbiter: RTL and testbench

Round-robin arbiter that shares one exclusive lock flag between `N_REQ` requesters. A requester raises `req`, receives a one-hot registered grant, holds it, and drops it with a one-cycle `rel` strobe. An optional hold limit revokes a grant that is held too long. It sits in front of any shared single-owner resource whose ownership flag the design would otherwise build from set/reset registers.

---
 rtl/lock_arbiter.sv | 172 +++++++++++++++++
 tb/tb_lock_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_arbiter.sv
// ---------------------------------------------------------------------------
// lock_arbiter
//
// Round-robin arbiter for one exclusive lock shared by N_REQ requesters.
// A requester raises its req bit and gets a one-hot registered grant. It keeps
// the grant until it pulses its rel bit for one cycle. If max_hold is nonzero,
// a grant held for max_hold cycles is revoked, and timeout pulses for one cycle.
//
// Parameters
//   N_REQ     number of requesters (2..16)
//   HOLD_W    width of max_hold and of the hold counter
//   IDX_W     width of owner_idx (derived, do not override)
//
// Ports
//   clk        in   system clock, rising edge
//   ares_L     in   asynchronous active-low reset
//   req        in   per-requester level request
//   rel        in   per-requester release strobe (honoured from owner only)
//   max_hold   in   hold limit in cycles, 0 = unlimited
//   gnt        out  one-hot grant or zero (registered)
//   busy       out  lock owned, equals OR of gnt (registered)
//   owner_idx  out  current owner, last owner while idle
//   timeout    out  one-cycle pulse after a hold-limit revocation
// ---------------------------------------------------------------------------
module lock_arbiter #(
   parameter int N_REQ  = 4,
   parameter int HOLD_W = 8,
   parameter int IDX_W  = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              ares_L,
   input  logic [N_REQ-1:0]  req,
   input  logic [N_REQ-1:0]  rel,
   input  logic [HOLD_W-1:0] max_hold,
   output logic [N_REQ-1:0]  gnt,
   output logic              busy,
   output logic [IDX_W-1:0]  owner_idx,
   output logic              timeout
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   state_t              state_q,   state_d;
   logic [N_REQ-1:0]    gnt_q,     gnt_d;
   logic                busy_q,    busy_d;
   logic [IDX_W-1:0]    owner_q,   owner_d;
   logic [HOLD_W-1:0]   hold_q,    hold_d;
   logic                timeout_q, timeout_d;

   // ------------------------------------------------------------------------
   // Round-robin search. Slot gi looks at requester (owner+1+gi) mod N_REQ,
   // so slot 0 is the highest priority and the previous owner lands in the
   // last slot. owner_q < N_REQ and the offset is <= N_REQ, so one
   // conditional subtraction is enough for the wrap.
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] cand_idx [N_REQ];
   logic [N_REQ-1:0] cand_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         logic [IDX_W:0] wrapped;
         assign sum      = {1'b0, owner_q} + (IDX_W+1)'(gi + 1);
         assign wrapped  = sum - (IDX_W+1)'(N_REQ);
         assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? wrapped[IDX_W-1:0]
                                                          : sum[IDX_W-1:0];
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;

   // Lowest-numbered hit slot wins; scanning downward lets it be the last write.
   always_comb begin
      pick_valid = |cand_hit;
      pick_idx   = owner_q;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            pick_idx = cand_idx[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   logic limit_hit;
   assign limit_hit = (max_hold != '0) && (hold_q >= max_hold);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // rel is ignored here; only a request can change the state.
            if (pick_valid) begin
               gnt_d   = ONE_HOT0 << pick_idx;
               owner_d = pick_idx;
               busy_d  = 1'b1;
               hold_d  = HOLD_W'(1);
               state_d = ST_OWNED;
            end
         end

         ST_OWNED: begin
            // Release has priority over the hold limit, so a coincident
            // release never produces a timeout pulse. Changes on req, and
            // rel from anyone but the owner, are ignored.
            if (rel[owner_q]) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (limit_hit) begin
               gnt_d     = '0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (hold_q != '1) begin
               // Saturate so a long unlimited hold still compares correctly
               // if a limit is applied later.
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers. owner resets to the last index so requester 0 is first.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge ares_L) begin
      if (!ares_L) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         owner_q   <= LAST_IDX;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign owner_idx = owner_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_lock_arbiter.sv
module tb_lock_arbiter;

   localparam int N  = 4;
   localparam int HW = 8;

   logic          clk;
   logic          ares_L;
   logic [N-1:0]  req;
   logic [N-1:0]  rel;
   logic [HW-1:0] max_hold;
   logic [N-1:0]  gnt;
   logic          busy;
   logic [1:0]    owner_idx;
   logic          timeout;

   int total = 0;
   int bad   = 0;

   lock_arbiter #(.N_REQ(N), .HOLD_W(HW)) dut (
      .clk       (clk),
      .ares_L    (ares_L),
      .req       (req),
      .rel       (rel),
      .max_hold  (max_hold),
      .gnt       (gnt),
      .busy      (busy),
      .owner_idx (owner_idx),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Invariants, checked on the falling edge every cycle.
   always @(negedge clk) begin
      total++;
      if (!$onehot0(gnt) || (busy !== (|gnt)) || (timeout && busy)) begin
         bad++;
         $display("FAIL invariant t=%0t gnt=%b busy=%b timeout=%b (need onehot0, busy=|gnt, !(timeout&busy))",
                  $time, gnt, busy, timeout);
      end
   end

   // Advance one rising edge and settle; outputs now reflect that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ares_L   = 1'b0;
      req      = '0;
      rel      = '0;
      max_hold = '0;
      step();
      step();
      ares_L   = 1'b1;
   endtask

   task automatic test_reset();
      ares_L = 1'b0; req = '0; rel = '0; max_hold = '0;
      step();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner_idx !== 2'd3) begin
         bad++;
         $display("FAIL reset_state got gnt=%b busy=%b to=%b own=%0d need 0000 0 0 3", gnt, busy, timeout, owner_idx);
      end
      req = 4'b1111;
      ares_L = 1'b1;
      step();
      total++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || owner_idx !== 2'd0) begin
         bad++;
         $display("FAIL first_grant got gnt=%b busy=%b own=%0d need 0001 1 0", gnt, busy, owner_idx);
      end
      step();
      // Asynchronous reset in the middle of a grant.
      #2 ares_L = 1'b0;
      #1;
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || owner_idx !== 2'd3) begin
         bad++;
         $display("FAIL async_reset got gnt=%b busy=%b own=%0d need 0000 0 3", gnt, busy, owner_idx);
      end
      step();
      ares_L = 1'b1;
      step();
      total++;
      if (gnt !== 4'b0001 || owner_idx !== 2'd0) begin
         bad++;
         $display("FAIL regrant_after_reset got gnt=%b own=%0d need 0001 0", gnt, owner_idx);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] exp_g;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         step();
         total++;
         if (gnt !== exp_g || owner_idx !== 2'(k % 4)) begin
            bad++;
            $display("FAIL rotation_grant k=%0d got gnt=%b own=%0d need %b %0d", k, gnt, owner_idx, exp_g, k % 4);
         end
         rel = exp_g;
         step();
         rel = '0;
         total++;
         if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL rotation_idle k=%0d got gnt=%b busy=%b to=%b need 0000 0 0", k, gnt, busy, timeout);
         end
      end
   endtask

   task automatic test_hold_limit();
      do_reset();
      max_hold = 8'd3;
      req = 4'b0100;
      for (int c = 1; c <= 3; c++) begin
         step();
         total++;
         if (gnt !== 4'b0100 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL hold_cycle c=%0d got gnt=%b to=%b need 0100 0", c, gnt, timeout);
         end
      end
      step();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1 || owner_idx !== 2'd2) begin
         bad++;
         $display("FAIL hold_revoke got gnt=%b busy=%b to=%b own=%0d need 0000 0 1 2", gnt, busy, timeout, owner_idx);
      end
      step();
      total++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL hold_regrant got gnt=%b to=%b need 0100 0", gnt, timeout);
      end
   endtask

   task automatic test_rel_beats_timeout();
      do_reset();
      max_hold = 8'd2;
      req = 4'b0001;
      step();
      step();
      rel = 4'b0001;
      step();
      rel = '0;
      total++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL rel_beats_timeout got gnt=%b to=%b need 0000 0", gnt, timeout);
      end
   endtask

   task automatic test_nonowner_rel();
      do_reset();
      req = 4'b0011;
      step();
      rel = 4'b0010;
      step();
      rel = '0;
      total++;
      if (gnt !== 4'b0001 || owner_idx !== 2'd0) begin
         bad++;
         $display("FAIL nonowner_rel got gnt=%b own=%0d need 0001 0", gnt, owner_idx);
      end
   endtask

   task automatic test_owner_drops_req();
      do_reset();
      req = 4'b0100;
      step();
      req = 4'b0001;
      step();
      step();
      total++;
      if (gnt !== 4'b0100) begin
         bad++;
         $display("FAIL owner_drop_keeps got gnt=%b need 0100", gnt);
      end
      rel = 4'b0100;
      step();
      rel = '0;
      total++;
      if (gnt !== 4'b0000) begin
         bad++;
         $display("FAIL owner_drop_release got gnt=%b need 0000", gnt);
      end
      step();
      total++;
      if (gnt !== 4'b0001 || owner_idx !== 2'd0) begin
         bad++;
         $display("FAIL owner_drop_next got gnt=%b own=%0d need 0001 0", gnt, owner_idx);
      end
   endtask

   task automatic test_rel_idle_and_lower_limit();
      do_reset();
      // rel while idle is ignored: grant still happens and sticks.
      req = 4'b0001;
      rel = 4'b0001;
      step();
      rel = '0;
      step();
      total++;
      if (gnt !== 4'b0001) begin
         bad++;
         $display("FAIL rel_idle got gnt=%b need 0001", gnt);
      end
      repeat (4) step();
      // counter is 6 now; lowering the limit revokes on the next edge
      max_hold = 8'd2;
      step();
      total++;
      if (gnt !== 4'b0000 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL lower_limit got gnt=%b to=%b need 0000 1", gnt, timeout);
      end
   endtask

   task automatic test_saturation();
      int hi;
      do_reset();
      max_hold = 8'd255;
      req = 4'b1000;
      step();
      hi = 0;
      while (gnt === 4'b1000 && hi < 300) begin
         hi++;
         step();
      end
      total++;
      if (hi != 255 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL max_limit got cycles=%0d to=%b need 255 1", hi, timeout);
      end
      max_hold = '0;
      step();
      repeat (300) step();
      max_hold = 8'd255;
      step();
      total++;
      if (gnt !== 4'b0000 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL saturated_compare got gnt=%b to=%b need 0000 1", gnt, timeout);
      end
   endtask

   task automatic test_stress();
      logic [N-1:0] req_s;
      logic [N-1:0] sampled;
      logic [N-1:0] prev_gnt;
      int           wait_cnt [N];
      do_reset();
      req_s = '0;
      prev_gnt = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(7) == 0) req_s[i] = ~req_s[i];
         end
         req = req_s;
         rel = ($urandom_range(2) == 0) ? gnt : 4'b0000;
         if ($urandom_range(3) == 0) rel = rel | 4'($urandom_range(15));
         if ($urandom_range(63) == 0) max_hold = 8'($urandom_range(6));
         sampled = req;
         step();
         if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < N; i++) begin
               if (gnt[i]) begin
                  wait_cnt[i] = 0;
               end else if (sampled[i]) begin
                  wait_cnt[i]++;
                  total++;
                  if (wait_cnt[i] > N) begin
                     bad++;
                     $display("FAIL fairness req=%0d got waited=%0d grants need <=%0d", i, wait_cnt[i], N);
                  end
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!sampled[i]) wait_cnt[i] = 0;
         end
         prev_gnt = gnt;
      end
      rel = '0;
      req = '0;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_hold_limit();
      test_rel_beats_timeout();
      test_nonowner_rel();
      test_owner_drops_req();
      test_rel_idle_and_lower_limit();
      test_saturation();
      test_stress();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
